// File: rtl/id_ex_issue_if.sv
// ----------------------------------------------------------------------------
// id_ex_issue_if
//   Bundles the decode/issue stage signals. The id_* group is the
//   fetch/regfile side, the ex_* group is the execute side (ALU stage).
//   Also holds the shared XLEN and ALU operation code definitions.
//
//   modport master : the issue stage (consumes id_*, produces ex_*)
//   modport slave  : the surroundings (produce id_*, consume ex_*)
// ----------------------------------------------------------------------------
`ifndef ID_EX_ISSUE_DEFINES
`define ID_EX_ISSUE_DEFINES
`define XLEN          32
`define ALU_OP_WIDTH  5
`define ALU_OP_NOP    5'd0
`define ALU_OP_ADD    5'd1
`define ALU_OP_SUB    5'd2
`define ALU_OP_SLL    5'd3
`define ALU_OP_SLT    5'd4
`define ALU_OP_SLTU   5'd5
`define ALU_OP_XOR    5'd6
`define ALU_OP_SRL    5'd7
`define ALU_OP_SRA    5'd8
`define ALU_OP_OR     5'd9
`define ALU_OP_AND    5'd10
`define ALU_OP_EQ     5'd11
`define ALU_OP_NE     5'd12
`define ALU_OP_LT     5'd13
`define ALU_OP_GE     5'd14
`define ALU_OP_LTU    5'd15
`define ALU_OP_GEU    5'd16
`endif

interface id_ex_issue_if;
    // Fetch / regfile side
    logic                     id_valid;
    logic                     id_ready;
    logic [31:0]              id_instr;
    logic [`XLEN-1:0]         id_pc;
    logic [4:0]               id_rs1_addr;
    logic [4:0]               id_rs2_addr;
    logic [`XLEN-1:0]         id_rs1_data;
    logic [`XLEN-1:0]         id_rs2_data;
    logic                     flush;
    // Execute side
    logic                     ex_valid;
    logic                     ex_ready;
    logic [`ALU_OP_WIDTH-1:0] ex_alu_op;
    logic [`XLEN-1:0]         ex_alu_src1;
    logic [`XLEN-1:0]         ex_alu_src2;
    logic [`XLEN-1:0]         ex_pc;
    logic [`XLEN-1:0]         ex_imm;
    logic [4:0]               ex_rd;
    logic                     ex_rd_we;
    logic                     ex_is_branch;
    logic                     ex_is_jump;
    logic                     ex_illegal;

    modport master (
        input  id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data, flush, ex_ready,
        output id_ready, id_rs1_addr, id_rs2_addr,
        output ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2, ex_pc, ex_imm,
               ex_rd, ex_rd_we, ex_is_branch, ex_is_jump, ex_illegal
    );

    modport slave (
        output id_valid, id_instr, id_pc, id_rs1_data, id_rs2_data, flush, ex_ready,
        input  id_ready, id_rs1_addr, id_rs2_addr,
        input  ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2, ex_pc, ex_imm,
               ex_rd, ex_rd_we, ex_is_branch, ex_is_jump, ex_illegal
    );
endinterface

// File: rtl/id_ex_issue.sv
// ----------------------------------------------------------------------------
// id_ex_issue
//   RV32I decode/issue stage. Decodes one instruction per id handshake into
//   ALU op/operands plus side info and holds it in a 1-entry ID/EX register
//   with valid/ready flow control and flush.
//
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : id_ex_issue_if.master
//          id_valid/id_ready handshake, id_instr, id_pc, regfile read
//          addresses (combinational from id_instr) and data, flush,
//          ex_valid/ex_ready handshake and the registered ex_* decode fields.
// ----------------------------------------------------------------------------
module id_ex_issue (
    input  logic          clk,
    input  logic          rst,
    id_ex_issue_if.master bus
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [`ALU_OP_WIDTH-1:0] alu_op;
        logic [`XLEN-1:0]         src1;
        logic [`XLEN-1:0]         src2;
        logic [`XLEN-1:0]         pc;
        logic [`XLEN-1:0]         imm;
        logic [4:0]               rd;
        logic                     rd_we;
        logic                     is_branch;
        logic                     is_jump;
        logic                     illegal;
    } dec_t;

    // ---------------------------------------------------------------- fields
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = bus.id_instr;
    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign bus.id_rs1_addr = instr[19:15];
    assign bus.id_rs2_addr = instr[24:20];

    // Shared f3 map of R and I arithmetic; SUB only exists in the R form,
    // so an I-type immediate with bit 30 set still decodes as ADD.
    function automatic logic [`ALU_OP_WIDTH-1:0] arith_op(input logic [2:0] fn3,
                                                          input logic       alt,
                                                          input logic       allow_sub);
        case (fn3)
            3'b000:  arith_op = (alt && allow_sub) ? `ALU_OP_SUB : `ALU_OP_ADD;
            3'b001:  arith_op = `ALU_OP_SLL;
            3'b010:  arith_op = `ALU_OP_SLT;
            3'b011:  arith_op = `ALU_OP_SLTU;
            3'b100:  arith_op = `ALU_OP_XOR;
            3'b101:  arith_op = alt ? `ALU_OP_SRA : `ALU_OP_SRL;
            3'b110:  arith_op = `ALU_OP_OR;
            default: arith_op = `ALU_OP_AND;
        endcase
    endfunction

    // ---------------------------------------------------------------- decode
    dec_t dec;

    always_comb begin
        // NOTE: every field gets a default before the case so that no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        dec        = '0;
        dec.alu_op = `ALU_OP_NOP;
        dec.pc     = bus.id_pc;

        case (opcode)
            OPC_R: begin
                dec.src1  = bus.id_rs1_data;
                dec.src2  = bus.id_rs2_data;
                dec.rd    = rd_f;
                dec.rd_we = 1'b1;
                if (f7 == 7'h00 || f7 == 7'h20) dec.alu_op  = arith_op(f3, f7[5], 1'b1);
                else                            dec.illegal = 1'b1;
            end
            OPC_I: begin
                dec.src1   = bus.id_rs1_data;
                // Shifts carry only the 5-bit shamt; bit 30 selects SRA.
                dec.src2   = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instr[24:20]} : imm_i;
                dec.imm    = imm_i;
                dec.rd     = rd_f;
                dec.rd_we  = 1'b1;
                dec.alu_op = arith_op(f3, instr[30], 1'b0);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.src1   = (opcode == OPC_AUIPC) ? bus.id_pc : '0;
                dec.src2   = imm_u;
                dec.imm    = imm_u;
                dec.rd     = rd_f;
                dec.rd_we  = 1'b1;
                dec.alu_op = `ALU_OP_ADD;
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU computes the link address pc+4; the target uses imm.
                dec.src1    = bus.id_pc;
                dec.src2    = 32'd4;
                dec.imm     = (opcode == OPC_JAL) ? imm_j : imm_i;
                dec.rd      = rd_f;
                dec.rd_we   = 1'b1;
                dec.is_jump = 1'b1;
                dec.alu_op  = `ALU_OP_ADD;
                if (opcode == OPC_JALR && f3 != 3'b000) dec.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.src1      = bus.id_rs1_data;
                dec.src2      = bus.id_rs2_data;
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000:  dec.alu_op  = `ALU_OP_EQ;
                    3'b001:  dec.alu_op  = `ALU_OP_NE;
                    3'b100:  dec.alu_op  = `ALU_OP_LT;
                    3'b101:  dec.alu_op  = `ALU_OP_GE;
                    3'b110:  dec.alu_op  = `ALU_OP_LTU;
                    3'b111:  dec.alu_op  = `ALU_OP_GEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.src1   = bus.id_rs1_data;
                dec.src2   = imm_i;
                dec.imm    = imm_i;
                dec.rd     = rd_f;
                dec.rd_we  = 1'b1;
                dec.alu_op = `ALU_OP_ADD;
            end
            OPC_STORE: begin
                dec.src1   = bus.id_rs1_data;
                dec.src2   = imm_s;
                dec.imm    = imm_s;
                dec.alu_op = `ALU_OP_ADD;
            end
            default: dec.illegal = 1'b1;
        endcase

        // An undecodable word issues as a bubble that only carries the flag.
        if (dec.illegal) begin
            dec         = '0;
            dec.pc      = bus.id_pc;
            dec.alu_op  = `ALU_OP_NOP;
            dec.illegal = 1'b1;
        end

        // Writes to x0 are architecturally discarded.
        if (dec.rd == 5'd0) dec.rd_we = 1'b0;
    end

    // ------------------------------------------------------- ID/EX register
    dec_t ex_q;
    logic ex_valid_q;
    logic accept;

    assign bus.id_ready = !ex_valid_q || bus.ex_ready;
    assign accept       = bus.id_valid && bus.id_ready;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_q        <= '0;
            ex_q.alu_op <= `ALU_OP_NOP;
        end else if (bus.flush) begin
            // Flush wins over both the held entry and the incoming one.
            ex_valid_q  <= 1'b0;
            ex_q        <= '0;
            ex_q.alu_op <= `ALU_OP_NOP;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= dec;
        end else if (ex_valid_q && bus.ex_ready) begin
            // Consumed with nothing behind it: drop valid, fields just hold.
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_alu_src1  = ex_q.src1;
    assign bus.ex_alu_src2  = ex_q.src2;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_rd_we     = ex_q.rd_we;
    assign bus.ex_is_branch = ex_q.is_branch;
    assign bus.ex_is_jump   = ex_q.is_jump;
    assign bus.ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// ----------------------------------------------------------------------------
// tb_id_ex_issue
//   Directed bench for id_ex_issue. Expected decode results are written as
//   constants, queued when an instruction is accepted and popped when the
//   ID/EX register presents it.
// ----------------------------------------------------------------------------
module tb_id_ex_issue;

    localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,
                           OP_SRA = 5'd8,  OP_NE  = 5'd12;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] src1, src2, pc, imm;
        logic [4:0]  rd;
        logic        rd_we, br, jmp, ill;
        logic        chk_src, chk_imm;
    } exp_t;

    logic clk;
    logic rst;
    id_ex_issue_if bus ();

    id_ex_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                                input logic we, input logic br, input logic jmp, input logic ill,
                                input logic chk_src, input logic chk_imm);
        exp_t e;
        e.op = op; e.src1 = s1; e.src2 = s2; e.pc = pc; e.imm = imm; e.rd = rd;
        e.rd_we = we; e.br = br; e.jmp = jmp; e.ill = ill;
        e.chk_src = chk_src; e.chk_imm = chk_imm;
        return e;
    endfunction

    // Compare the held entry against the oldest scoreboard item.
    task automatic check_head(input string tag);
        exp_t e;
        check({tag, ".sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".valid"},  bus.ex_valid,     1);
            check({tag, ".op"},     bus.ex_alu_op,    e.op);
            check({tag, ".pc"},     bus.ex_pc,        e.pc);
            check({tag, ".rd_we"},  bus.ex_rd_we,     e.rd_we);
            check({tag, ".branch"}, bus.ex_is_branch, e.br);
            check({tag, ".jump"},   bus.ex_is_jump,   e.jmp);
            check({tag, ".ill"},    bus.ex_illegal,   e.ill);
            if (e.chk_src) begin
                check({tag, ".src1"}, bus.ex_alu_src1, e.src1);
                check({tag, ".src2"}, bus.ex_alu_src2, e.src2);
            end
            if (e.chk_imm) check({tag, ".imm"}, bus.ex_imm, e.imm);
            if (e.rd_we)   check({tag, ".rd"},  bus.ex_rd,  e.rd);
        end
    endtask

    // Present one instruction, wait (bounded) for acceptance, queue the
    // expectation, then release id_valid and check the loaded entry.
    task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        int n;
        bus.id_valid    = 1'b1;
        bus.id_instr    = instr;
        bus.id_pc       = pc;
        bus.id_rs1_data = r1;
        bus.id_rs2_data = r2;
        n = 0;
        while (!bus.id_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".id_ready"}, bus.id_ready, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.id_valid = 1'b0;
        check_head(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.id_valid    = 1'b0;
        bus.id_instr    = 32'h0;
        bus.id_pc       = 32'h0;
        bus.id_rs1_data = 32'h0;
        bus.id_rs2_data = 32'h0;
        bus.flush       = 1'b0;
        bus.ex_ready    = 1'b1;

        // Reset state
        #1;
        check("rst.valid",    bus.ex_valid,    0);
        check("rst.op",       bus.ex_alu_op,   OP_NOP);
        check("rst.src1",     bus.ex_alu_src1, 0);
        check("rst.rd_we",    bus.ex_rd_we,    0);
        check("rst.id_ready", bus.id_ready,    1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic decode
        send("addi", 32'h00500093, 32'h0, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'h5, 32'h0, 32'h5, 5'd1, 1, 0, 0, 0, 1, 1));

        bus.id_instr = 32'h402081B3;
        #1;
        check("sub.rs1_addr", bus.id_rs1_addr, 1);
        check("sub.rs2_addr", bus.id_rs2_addr, 2);
        send("sub", 32'h402081B3, 32'h4, 32'd9, 32'd4,
             mk(OP_SUB, 32'd9, 32'd4, 32'h4, 32'h0, 5'd3, 1, 0, 0, 0, 1, 0));
        send("srai", 32'h40335293, 32'h8, 32'h80000000, 32'h0,
             mk(OP_SRA, 32'h80000000, 32'd3, 32'h8, 32'h0, 5'd5, 1, 0, 0, 0, 1, 0));
        send("bne", 32'h00209463, 32'h100, 32'h11, 32'h22,
             mk(OP_NE, 32'h11, 32'h22, 32'h100, 32'd8, 5'd0, 0, 1, 0, 0, 1, 1));
        send("jal", 32'h010000EF, 32'h200, 32'h0, 32'h0,
             mk(OP_ADD, 32'h200, 32'd4, 32'h200, 32'd16, 5'd1, 1, 0, 1, 0, 1, 1));
        send("jalr_x0", 32'h00008067, 32'h300, 32'h77, 32'h0,
             mk(OP_ADD, 32'h300, 32'd4, 32'h300, 32'h0, 5'd0, 0, 0, 1, 0, 1, 1));
        send("lui", 32'h12345137, 32'h304, 32'h99, 32'h0,
             mk(OP_ADD, 32'h0, 32'h12345000, 32'h304, 32'h12345000, 5'd2, 1, 0, 0, 0, 1, 0));
        send("auipc", 32'h00001217, 32'h400, 32'h0, 32'h0,
             mk(OP_ADD, 32'h400, 32'h1000, 32'h400, 32'h1000, 5'd4, 1, 0, 0, 0, 1, 0));
        send("sw", 32'hFE20AE23, 32'h404, 32'h1000, 32'h55,
             mk(OP_ADD, 32'h1000, 32'hFFFFFFFC, 32'h404, 32'hFFFFFFFC, 5'd0, 0, 0, 0, 0, 1, 1));

        // Illegal words and x0 destination
        send("ill_ones", 32'hFFFFFFFF, 32'h408, 32'h0, 32'h0,
             mk(OP_NOP, 32'h0, 32'h0, 32'h408, 32'h0, 5'd0, 0, 0, 0, 1, 0, 0));
        send("addi_x0", 32'h00000013, 32'h40C, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'h0, 32'h40C, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1));
        send("ill_bf3", 32'h00002063, 32'h410, 32'h0, 32'h0,
             mk(OP_NOP, 32'h0, 32'h0, 32'h410, 32'h0, 5'd0, 0, 0, 0, 1, 0, 0));
        send("ill_f7", 32'h02208033, 32'h414, 32'h0, 32'h0,
             mk(OP_NOP, 32'h0, 32'h0, 32'h414, 32'h0, 5'd0, 0, 0, 0, 1, 0, 0));

        // Drain: consumed with nothing behind it
        @(posedge clk); #1;
        check("drain.valid", bus.ex_valid, 0);

        // Stall: A held for 3 cycles while B waits, then B loads
        bus.ex_ready = 1'b0;
        send("stall_a", 32'h00100393, 32'h500, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'd1, 32'h500, 32'd1, 5'd7, 1, 0, 0, 0, 1, 1));
        bus.id_valid = 1'b1;
        bus.id_instr = 32'h00200413;
        bus.id_pc    = 32'h504;
        for (int i = 0; i < 3; i++) begin
            check("stall.id_ready", bus.id_ready,    0);
            check("stall.valid",    bus.ex_valid,    1);
            check("stall.src2",     bus.ex_alu_src2, 1);
            check("stall.rd",       bus.ex_rd,       7);
            check("stall.pc",       bus.ex_pc,       32'h500);
            @(posedge clk); #1;
        end
        bus.ex_ready = 1'b1;
        send("stall_b", 32'h00200413, 32'h504, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'd2, 32'h504, 32'd2, 5'd8, 1, 0, 0, 0, 1, 1));

        // Flush with an incoming instruction: both dropped
        bus.id_valid = 1'b1;
        bus.id_instr = 32'h00300493;
        bus.id_pc    = 32'h508;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.id_valid = 1'b0;
        check("flush.valid", bus.ex_valid,  0);
        check("flush.op",    bus.ex_alu_op, OP_NOP);
        @(posedge clk); #1;
        check("flush.dropped", bus.ex_valid, 0);

        // Flush during a stall
        bus.ex_ready = 1'b0;
        send("pre_flush", 32'h00500513, 32'h600, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'd5, 32'h600, 32'd5, 5'd10, 1, 0, 0, 0, 1, 1));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_stall.valid", bus.ex_valid,  0);
        check("flush_stall.op",    bus.ex_alu_op, OP_NOP);

        // Asynchronous reset in the middle of a stall
        send("pre_rst", 32'h00700593, 32'h700, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'd7, 32'h700, 32'd7, 5'd11, 1, 0, 0, 0, 1, 1));
        bus.id_valid = 1'b1;
        bus.id_instr = 32'h00800613;
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid.valid", bus.ex_valid,  0);
        check("rst_mid.op",    bus.ex_alu_op, OP_NOP);
        check("rst_mid.src2",  bus.ex_alu_src2, 0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b1;

        // Recovery after reset
        send("post_rst", 32'h00900693, 32'h800, 32'h0, 32'h0,
             mk(OP_ADD, 32'h0, 32'd9, 32'h800, 32'd9, 5'd13, 1, 0, 0, 0, 1, 1));

        check("sb.final_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
